mem_request_ctrl: RTL
=====================

# mem_request_ctrl

Request sequencer between the switch/key IO controller and the SDRAM controller's Avalon-MM slave port. Turns IO-controller events (write commit, read commit, entry into clear mode) into single-word or sweep memory transactions. Returns `memDone`/`memOut` to the IO controller, which holds its state machine while `memDone` is low.

## Interface
- `CLEAR_WORDS`, 1024: words zeroed by a clear sweep, addresses 0..CLEAR_WORDS-1; legal range 1..2^25.
- `READ_TIMEOUT`, 255: maximum cycles waited for `avmReadDataValid` after read acceptance; minimum 1.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `ioDone` in 1: IO-controller commit level.
- `modeOutput` in 2: IO mode. 00 clear, 01 read, 10 write-select, 11 idle/write-committed.
- `memoryAddress` in 25: word address.
- `ioDataOut` in 16: write data.
- `memDone` out 1: high = idle/ready; low = transaction in progress.
- `memOut` out 16: last read data.
- `memError` out 1: last read timed out.
- `avmAddress` out 25, `avmWriteData` out 16, `avmByteEnable` out 2: Avalon master address, data and enables.
- `avmRead` out 1, `avmWrite` out 1: Avalon master strobes.
- `avmWaitRequest` in 1, `avmReadData` in 16, `avmReadDataValid` in 1: Avalon slave responses.

## Operation
- Event detect: `ioDone` and `modeOutput` registered every cycle, including while busy. Event logic compares current against registered values.
  - startWrite: `ioDone` rising, `modeOutput`=11.
  - startRead: `ioDone` rising, `modeOutput`=01.
  - startClear: `modeOutput` changes to 00 from any other value.
  - Priority when several fire together: clear > write > read.
  - `ioDone` rising with mode 00 or 10: no action.
- `memoryAddress`/`ioDataOut` captured into internal registers in the cycle the event is accepted.
- States:
  - IDLE: `memDone`=1; strobes low. startClear → CLEAR_REQ with address 0. startWrite → WRITE_REQ. startRead → READ_REQ, and `memError` cleared.
  - WRITE_REQ: `avmWrite`=1, `avmByteEnable`=11, captured address/data. When `avmWaitRequest`=0 → IDLE.
  - READ_REQ: `avmRead`=1. When `avmWaitRequest`=0 → READ_WAIT; timeout counter cleared.
  - READ_WAIT: strobes low.
    - `avmReadDataValid`=1 → `memOut`←`avmReadData`, go IDLE.
    - Counter reaching READ_TIMEOUT → `memOut`←16'hDEAD, `memError`←1, go IDLE.
  - CLEAR_REQ: `avmWrite`=1, data 0, enables 11. On each accepted write, the address increments. Acceptance at address CLEAR_WORDS-1 → IDLE.
- Events arriving outside IDLE are dropped. The edge registers still update, so a dropped event is not replayed.
- `avmReadDataValid` outside READ_WAIT is ignored.
- Address counter is 26 bits internally, so CLEAR_WORDS=2^25 terminates without wrap. `avmAddress` is its low 25 bits.

## Timing
- Reset values: `memDone`=1, `memOut`=0, `memError`=0, `avmRead`=0, `avmWrite`=0, `avmAddress`=0, `avmWriteData`=0, `avmByteEnable`=00.
- All outputs are registered.
- Event in cycle N → `memDone`=0 and strobe asserted in N+1.
- Avalon outputs are held stable while `avmWaitRequest`=1.
- Write accepted in cycle M (strobe high, wait low): strobe low and `memDone`=1 in M+1. An unstalled write has `memDone` low for exactly 1 cycle.
- Read data valid in cycle V: `memOut` updated and `memDone`=1 in V+1.
- Clear with no wait states: CLEAR_WORDS consecutive write cycles, then `memDone`=1.
- Reset asserted mid-transaction: all outputs return to reset values on the next edge; the in-flight request is abandoned.

## Structure
- Shared package `mem_ctrl_pkg`:
  - mode encodings MODE_CLEAR=2'b00, MODE_READ=2'b01, MODE_WRITE=2'b10, MODE_IDLE=2'b11, shared with the IO controller;
  - state enum `memReqState_t`;
  - constant TIMEOUT_DATA=16'hDEAD.
- One sub-module, `mem_req_event_detect`: input registers plus prioritized startClear/startWrite/startRead pulses.

## Test plan
- Write: mode 11, address 25'h0_1234, data 16'hBEEF, `ioDone` 0→1, no wait → one `avmWrite` cycle at 25'h0_1234 carrying BEEF; `memDone` low exactly 1 cycle.
- Read after the write: mode 01, `ioDone` rise; slave returns 16'hBEEF 3 cycles after acceptance → `memOut`=BEEF, `memError`=0, `memDone` high the cycle after valid.
- Stalled write: `avmWaitRequest` held high 5 cycles → address/data/strobe stable for 6 cycles; exactly one write accepted.
- Clear with CLEAR_WORDS=8: mode 01→00 → writes of 0 to addresses 0..7 in order.
  - `ioDone` pulses during the sweep are ignored.
  - `memDone` returns high after address 7 is accepted.
- Timeout with READ_TIMEOUT=4, no valid returned → `memOut`=16'hDEAD, `memError`=1. The next successful read clears `memError`.
- Reset asserted mid-clear at address 3 → strobes low, `memDone`=1 next cycle. A subsequent read works normally.

Source files
------------

// File: rtl/mem_request_ctrl_pkg.sv
// Shared definitions for the memory request sequencer and the IO controller
// that feeds it: mode encodings, bus widths, FSM state type and the
// read-timeout marker word.
package mem_ctrl_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    // IO controller mode encodings
    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_IDLE  = 2'b11;

    // Returned in memOut when a read never produced data
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD;

    localparam logic [BE_W-1:0] BE_ALL  = 2'b11;
    localparam logic [BE_W-1:0] BE_NONE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE_REQ,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_CLEAR_REQ
    } memReqState_t;

endpackage

// File: rtl/mem_request_ctrl_if.sv
// Signal bundle between the IO controller, the request sequencer and the
// SDRAM controller's Avalon-MM slave. The sequencer is the Avalon master.
interface mem_request_ctrl_if;
    import mem_ctrl_pkg::*;

    // IO controller side
    logic              ioDone;
    logic [1:0]        modeOutput;
    logic [ADDR_W-1:0] memoryAddress;
    logic [DATA_W-1:0] ioDataOut;
    logic              memDone;
    logic [DATA_W-1:0] memOut;
    logic              memError;

    // Avalon-MM side
    logic [ADDR_W-1:0] avmAddress;
    logic [DATA_W-1:0] avmWriteData;
    logic [BE_W-1:0]   avmByteEnable;
    logic              avmRead;
    logic              avmWrite;
    logic              avmWaitRequest;
    logic [DATA_W-1:0] avmReadData;
    logic              avmReadDataValid;

    // Sequencer view
    modport master (
        input  ioDone, modeOutput, memoryAddress, ioDataOut,
        output memDone, memOut, memError,
        output avmAddress, avmWriteData, avmByteEnable, avmRead, avmWrite,
        input  avmWaitRequest, avmReadData, avmReadDataValid
    );

    // Environment view: IO controller plus SDRAM slave
    modport slave (
        output ioDone, modeOutput, memoryAddress, ioDataOut,
        input  memDone, memOut, memError,
        input  avmAddress, avmWriteData, avmByteEnable, avmRead, avmWrite,
        output avmWaitRequest, avmReadData, avmReadDataValid
    );

endinterface

// File: rtl/mem_request_ctrl_event_detect.sv
// Turns IO controller levels into one-cycle start pulses. ioDone and
// modeOutput are registered every cycle; an event is the difference between
// the current and registered values. Only one pulse is ever high.
module mem_req_event_detect
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       i_io_done,
    input  logic [1:0] i_mode,
    output logic       o_start_clear,
    output logic       o_start_write,
    output logic       o_start_read
);

    logic       r_io_done;
    logic [1:0] r_mode;
    logic       w_io_rise;
    logic       w_clear_raw;
    logic       w_write_raw;
    logic       w_read_raw;

    // Track the inputs every cycle, reset included, so leaving reset with
    // mode already at clear does not look like a fresh entry into clear mode.
    always_ff @(posedge clk) begin
        r_io_done <= i_io_done;
        r_mode    <= i_mode;
    end

    // Raw events then fixed priority clear > write > read.
    always_comb begin
        w_io_rise     = i_io_done & ~r_io_done;
        w_clear_raw   = (i_mode == MODE_CLEAR) && (r_mode != MODE_CLEAR);
        w_write_raw   = w_io_rise && (i_mode == MODE_IDLE);
        w_read_raw    = w_io_rise && (i_mode == MODE_READ);
        o_start_clear = w_clear_raw;
        o_start_write = w_write_raw & ~w_clear_raw;
        o_start_read  = w_read_raw & ~w_clear_raw & ~w_write_raw;
    end

endmodule

// File: rtl/mem_request_ctrl.sv
// Request sequencer: converts IO controller events into single-word Avalon
// writes/reads or a zeroing sweep over addresses 0..CLEAR_WORDS-1.
// Every output is a register; the combinational block computes next values.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | memDone high, strobes low, waiting for an event
// ST_WRITE_REQ | avmWrite high with captured address/data until accepted
// ST_READ_REQ  | avmRead high with captured address until accepted
// ST_READ_WAIT | strobes low, waiting for readdatavalid or the timeout
// ST_CLEAR_REQ | avmWrite of zero, address stepping on each acceptance
module mem_request_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int CLEAR_WORDS  = 1024,
    parameter int READ_TIMEOUT = 255
)
(
    input  logic                clk,
    input  logic                reset,
    mem_request_ctrl_if.master  bus
);

    // Down-counter loaded with READ_TIMEOUT-1 at acceptance; reaching zero
    // without data on the last allowed cycle means the read timed out.
    localparam int                TO_W     = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(READ_TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    // 26-bit sweep counter so a full 2^25-word sweep ends without wrapping
    localparam logic [ADDR_W:0]   CLR_LAST = (ADDR_W + 1)'(CLEAR_WORDS - 1);
    localparam logic [ADDR_W:0]   CLR_ONE  = (ADDR_W + 1)'(1);

    memReqState_t      r_state,        w_state;
    logic              r_mem_done,     w_mem_done;
    logic [DATA_W-1:0] r_mem_out,      w_mem_out;
    logic              r_mem_error,    w_mem_error;
    logic [ADDR_W-1:0] r_avm_address,  w_avm_address;
    logic [DATA_W-1:0] r_avm_wdata,    w_avm_wdata;
    logic [BE_W-1:0]   r_avm_be,       w_avm_be;
    logic              r_avm_read,     w_avm_read;
    logic              r_avm_write,    w_avm_write;
    logic [ADDR_W:0]   r_clr_addr,     w_clr_addr;
    logic [TO_W-1:0]   r_to_cnt,       w_to_cnt;

    logic              w_start_clear;
    logic              w_start_write;
    logic              w_start_read;

    mem_req_event_detect u_event_detect (
        .clk           (clk),
        .i_io_done     (bus.ioDone),
        .i_mode        (bus.modeOutput),
        .o_start_clear (w_start_clear),
        .o_start_write (w_start_write),
        .o_start_read  (w_start_read)
    );

    // State and output registers; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mem_done    <= 1'b1;
            r_mem_out     <= '0;
            r_mem_error   <= 1'b0;
            r_avm_address <= '0;
            r_avm_wdata   <= '0;
            r_avm_be      <= BE_NONE;
            r_avm_read    <= 1'b0;
            r_avm_write   <= 1'b0;
            r_clr_addr    <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_state       <= w_state;
            r_mem_done    <= w_mem_done;
            r_mem_out     <= w_mem_out;
            r_mem_error   <= w_mem_error;
            r_avm_address <= w_avm_address;
            r_avm_wdata   <= w_avm_wdata;
            r_avm_be      <= w_avm_be;
            r_avm_read    <= w_avm_read;
            r_avm_write   <= w_avm_write;
            r_clr_addr    <= w_clr_addr;
            r_to_cnt      <= w_to_cnt;
        end
    end

    // Next state and next output values; holding by default keeps the bus
    // stable while the slave asserts waitrequest.
    always_comb begin
        w_state       = r_state;
        w_mem_done    = r_mem_done;
        w_mem_out     = r_mem_out;
        w_mem_error   = r_mem_error;
        w_avm_address = r_avm_address;
        w_avm_wdata   = r_avm_wdata;
        w_avm_be      = r_avm_be;
        w_avm_read    = r_avm_read;
        w_avm_write   = r_avm_write;
        w_clr_addr    = r_clr_addr;
        w_to_cnt      = r_to_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_start_clear) begin
                    w_state       = ST_CLEAR_REQ;
                    w_clr_addr    = '0;
                    w_avm_address = '0;
                    w_avm_wdata   = '0;
                    w_avm_be      = BE_ALL;
                    w_avm_write   = 1'b1;
                    w_mem_done    = 1'b0;
                end else if (w_start_write) begin
                    w_state       = ST_WRITE_REQ;
                    w_avm_address = bus.memoryAddress;
                    w_avm_wdata   = bus.ioDataOut;
                    w_avm_be      = BE_ALL;
                    w_avm_write   = 1'b1;
                    w_mem_done    = 1'b0;
                end else if (w_start_read) begin
                    w_state       = ST_READ_REQ;
                    w_avm_address = bus.memoryAddress;
                    w_avm_be      = BE_ALL;
                    w_avm_read    = 1'b1;
                    w_mem_error   = 1'b0;
                    w_mem_done    = 1'b0;
                end
            end

            ST_WRITE_REQ: begin
                if (!bus.avmWaitRequest) begin
                    w_state     = ST_IDLE;
                    w_avm_write = 1'b0;
                    w_avm_be    = BE_NONE;
                    w_mem_done  = 1'b1;
                end
            end

            ST_READ_REQ: begin
                if (!bus.avmWaitRequest) begin
                    w_state    = ST_READ_WAIT;
                    w_avm_read = 1'b0;
                    w_avm_be   = BE_NONE;
                    w_to_cnt   = TO_LOAD;
                end
            end

            ST_READ_WAIT: begin
                if (bus.avmReadDataValid) begin
                    w_state    = ST_IDLE;
                    w_mem_out  = bus.avmReadData;
                    w_mem_done = 1'b1;
                end else if (r_to_cnt == '0) begin
                    w_state     = ST_IDLE;
                    w_mem_out   = TIMEOUT_DATA;
                    w_mem_error = 1'b1;
                    w_mem_done  = 1'b1;
                end else begin
                    w_to_cnt = r_to_cnt - TO_ONE;
                end
            end

            ST_CLEAR_REQ: begin
                if (!bus.avmWaitRequest) begin
                    if (r_clr_addr == CLR_LAST) begin
                        w_state     = ST_IDLE;
                        w_avm_write = 1'b0;
                        w_avm_be    = BE_NONE;
                        w_mem_done  = 1'b1;
                    end else begin
                        w_clr_addr    = r_clr_addr + CLR_ONE;
                        w_avm_address = w_clr_addr[ADDR_W-1:0];
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign bus.memDone       = r_mem_done;
    assign bus.memOut        = r_mem_out;
    assign bus.memError      = r_mem_error;
    assign bus.avmAddress    = r_avm_address;
    assign bus.avmWriteData  = r_avm_wdata;
    assign bus.avmByteEnable = r_avm_be;
    assign bus.avmRead       = r_avm_read;
    assign bus.avmWrite      = r_avm_write;

endmodule
